// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key tracker: prefix decoder states,
// protocol byte values and seven-segment glyph encoding.
package ps2_pkg;

  typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] PS2_CTL_NUL     = 8'h00;
  localparam logic [7:0] PS2_CTL_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_CTL_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_CTL_ACK     = 8'hFA;
  localparam logic [7:0] PS2_CTL_BAT_ERR = 8'hFC;
  localparam logic [7:0] PS2_CTL_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_CTL_ERR     = 8'hFF;

  localparam logic [7:0] ASCII_NONE = 8'hFF;
  // Active-low encoding; callers invert for active-high panels.
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == PS2_CTL_NUL) || (b == PS2_CTL_BAT_OK) || (b == PS2_CTL_ECHO) ||
           (b == PS2_CTL_ACK) || (b == PS2_CTL_BAT_ERR) || (b == PS2_CTL_RESEND) ||
           (b == PS2_CTL_ERR);
  endfunction

  // Active-low glyph, bit 0 = segment a, bit 7 = dp (always off).
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      4'hF: g = 8'h8E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Set-2 scan code to ASCII lookup for digits, uppercase letters and space.
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = ASCII_NONE;
    if (!ext_i) begin
      case (code_i)
        8'h45: ascii_o = 8'h30;
        8'h16: ascii_o = 8'h31;
        8'h1E: ascii_o = 8'h32;
        8'h26: ascii_o = 8'h33;
        8'h25: ascii_o = 8'h34;
        8'h2E: ascii_o = 8'h35;
        8'h36: ascii_o = 8'h36;
        8'h3D: ascii_o = 8'h37;
        8'h3E: ascii_o = 8'h38;
        8'h46: ascii_o = 8'h39;
        8'h1C: ascii_o = 8'h41;
        8'h32: ascii_o = 8'h42;
        8'h21: ascii_o = 8'h43;
        8'h23: ascii_o = 8'h44;
        8'h24: ascii_o = 8'h45;
        8'h2B: ascii_o = 8'h46;
        8'h34: ascii_o = 8'h47;
        8'h33: ascii_o = 8'h48;
        8'h43: ascii_o = 8'h49;
        8'h3B: ascii_o = 8'h4A;
        8'h42: ascii_o = 8'h4B;
        8'h4B: ascii_o = 8'h4C;
        8'h3A: ascii_o = 8'h4D;
        8'h31: ascii_o = 8'h4E;
        8'h44: ascii_o = 8'h4F;
        8'h4D: ascii_o = 8'h50;
        8'h15: ascii_o = 8'h51;
        8'h2D: ascii_o = 8'h52;
        8'h1B: ascii_o = 8'h53;
        8'h2C: ascii_o = 8'h54;
        8'h3C: ascii_o = 8'h55;
        8'h2A: ascii_o = 8'h56;
        8'h1D: ascii_o = 8'h57;
        8'h22: ascii_o = 8'h58;
        8'h35: ascii_o = 8'h59;
        8'h1A: ascii_o = 8'h5A;
        8'h29: ascii_o = 8'h20;
        default: ascii_o = ASCII_NONE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 make/break prefixes, tracks the held key and its ASCII,
// counts distinct presses and drives a seven-segment digit bank.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_DIGITS     = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned CNT_SATURATE   = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [7:0]                    code_data_i,
  input  logic                          code_valid_i,
  output logic                          code_ready_o,
  output logic                          key_held_o,
  output logic                          key_ext_o,
  output logic [7:0]                    key_code_o,
  output logic [7:0]                    key_ascii_o,
  output logic [4*CNT_DIGITS-1:0]       press_cnt_o,
  output logic [8*(4+CNT_DIGITS)-1:0]   seg_o
);

  localparam int unsigned CW   = 4 * CNT_DIGITS;
  localparam int unsigned NDIG = 4 + CNT_DIGITS;
  localparam int unsigned SW   = 8 * NDIG;

  function automatic logic [7:0] seg_pol(input logic [7:0] g);
    return (SEG_ACTIVE_LOW != 0) ? g : ~g;
  endfunction

  function automatic logic [SW-1:0] seg_reset_val();
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) begin
      v[8*i +: 8] = seg_pol((i < 4) ? SEG_BLANK : hex_glyph(4'h0));
    end
    return v;
  endfunction

  localparam logic [SW-1:0] SegRst = seg_reset_val();

  logic          code_ready_q;
  ps2_state_e    state_q, state_d;
  logic          held_q, held_d;
  logic          ext_q, ext_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    ascii_q, ascii_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] seg_q, seg_d;

  logic       accept, is_data, make_ev, brk_ev, ev_ext, match;
  logic [7:0] lut_ascii;
  logic [4*NDIG-1:0] nibs;

  assign accept  = code_valid_i & code_ready_q;
  assign is_data = !is_ctrl(code_data_i) && (code_data_i != PS2_EXT) &&
                   (code_data_i != PS2_BRK);

  ps2_ascii_lut u_ascii_lut (
    .code_i  (code_data_i),
    .ext_i   (ev_ext),
    .ascii_o (lut_ascii)
  );

  always_comb begin
    state_d = state_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;
    if (accept) begin
      if (is_ctrl(code_data_i)) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (code_data_i == PS2_EXT)      state_d = StE0;
            else if (code_data_i == PS2_BRK) state_d = StF0;
            else                             make_ev = 1'b1;
          end
          StE0: begin
            ev_ext = 1'b1;
            if (code_data_i == PS2_BRK) begin
              state_d = StE0F0;
            end else if (code_data_i != PS2_EXT) begin
              make_ev = 1'b1;
              state_d = StIdle;
            end
          end
          StF0: begin
            brk_ev  = is_data;
            state_d = StIdle;
          end
          StE0F0: begin
            ev_ext  = 1'b1;
            brk_ev  = is_data;
            state_d = StIdle;
          end
        endcase
      end
    end
  end

  always_comb begin
    match   = held_q && (ext_q == ev_ext) && (code_q == code_data_i);
    held_d  = held_q;
    ext_d   = ext_q;
    code_d  = code_q;
    ascii_d = ascii_q;
    cnt_d   = cnt_q;
    // A make of the already-held key is typematic repeat and changes nothing.
    if (make_ev && !match) begin
      held_d  = 1'b1;
      ext_d   = ev_ext;
      code_d  = code_data_i;
      ascii_d = lut_ascii;
      cnt_d   = ((CNT_SATURATE != 0) && (&cnt_q)) ? cnt_q : cnt_q + CW'(1);
    end
    if (brk_ev && match) begin
      held_d = 1'b0;
    end
  end

  assign nibs = {cnt_q, ascii_q, code_q};

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      seg_d[8*i +: 8] = seg_pol((i < 4 && !held_q) ? SEG_BLANK : hex_glyph(nibs[4*i +: 4]));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      code_ready_q <= 1'b0;
      state_q      <= StIdle;
      held_q       <= 1'b0;
      ext_q        <= 1'b0;
      code_q       <= 8'h00;
      ascii_q      <= ASCII_NONE;
      cnt_q        <= '0;
      seg_q        <= SegRst;
    end else begin
      code_ready_q <= 1'b1;
      state_q      <= state_d;
      held_q       <= held_d;
      ext_q        <= ext_d;
      code_q       <= code_d;
      ascii_q      <= ascii_d;
      cnt_q        <= cnt_d;
      seg_q        <= seg_d;
    end
  end

  assign code_ready_o = code_ready_q;
  assign key_held_o   = held_q;
  assign key_ext_o    = ext_q;
  assign key_code_o   = code_q;
  assign key_ascii_o  = ascii_q;
  assign press_cnt_o  = cnt_q;
  assign seg_o        = seg_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised and directed bench for ps2_key_tracker against a prefix-flag reference model,
// covering the default build plus one-digit wrapping and saturating counter builds.
module tb_ps2_key_tracker;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] code_data_i;
  logic       code_valid_i;

  logic        rdy0, held0, ext0, rdy1, held1, ext1, rdy2, held2, ext2;
  logic [7:0]  kc0, ka0, kc1, ka1, kc2, ka2;
  logic [15:0] cnt0;
  logic [3:0]  cnt1, cnt2;
  logic [63:0] seg0;
  logic [39:0] seg1, seg2;

  always #5 clk_i = ~clk_i;

  ps2_key_tracker u_dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .code_data_i(code_data_i), .code_valid_i(code_valid_i),
    .code_ready_o(rdy0), .key_held_o(held0), .key_ext_o(ext0), .key_code_o(kc0),
    .key_ascii_o(ka0), .press_cnt_o(cnt0), .seg_o(seg0)
  );

  ps2_key_tracker #(.CNT_DIGITS(1), .SEG_ACTIVE_LOW(0), .CNT_SATURATE(0)) u_dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .code_data_i(code_data_i), .code_valid_i(code_valid_i),
    .code_ready_o(rdy1), .key_held_o(held1), .key_ext_o(ext1), .key_code_o(kc1),
    .key_ascii_o(ka1), .press_cnt_o(cnt1), .seg_o(seg1)
  );

  ps2_key_tracker #(.CNT_DIGITS(1), .SEG_ACTIVE_LOW(1), .CNT_SATURATE(1)) u_dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .code_data_i(code_data_i), .code_valid_i(code_valid_i),
    .code_ready_o(rdy2), .key_held_o(held2), .key_ext_o(ext2), .key_code_o(kc2),
    .key_ascii_o(ka2), .press_cnt_o(cnt2), .seg_o(seg2)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 0;

  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] glyphs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] ctl_bytes [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] key_pool [8]  = '{8'h1C, 8'h32, 8'h16, 8'h75, 8'h29, 8'h45, 8'h5A, 8'h66};

  // Reference model state
  bit         m_ready, m_held, m_ext, pend_ext, pend_brk;
  logic [7:0] m_code, m_ascii;
  int         m_raw;
  logic [63:0] exp_seg0;
  logic [39:0] exp_seg1, exp_seg2;

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit e);
    if (e) return 8'hFF;
    for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return 8'h30 + 8'(i);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == c) return 8'h41 + 8'(i);
    if (c == 8'h29) return 8'h20;
    return 8'hFF;
  endfunction

  function automatic bit ref_ctrl(input logic [7:0] b);
    for (int i = 0; i < 7; i++) if (ctl_bytes[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int cnt_wrap16(input int raw);  return raw % 65536; endfunction
  function automatic int cnt_wrap4(input int raw);   return raw % 16; endfunction
  function automatic int cnt_sat4(input int raw);    return (raw > 15) ? 15 : raw; endfunction

  function automatic logic [63:0] ref_seg(input bit held, input logic [7:0] code,
                                          input logic [7:0] ascii, input int cnt,
                                          input int ndig, input bit act_low);
    logic [63:0] v;
    logic [7:0]  g;
    int          nib;
    v = '0;
    for (int d = 0; d < 4 + ndig; d++) begin
      if (d == 0)      nib = int'(code) % 16;
      else if (d == 1) nib = int'(code) / 16;
      else if (d == 2) nib = int'(ascii) % 16;
      else if (d == 3) nib = int'(ascii) / 16;
      else             nib = (cnt >> (4 * (d - 4))) % 16;
      g = (d < 4 && !held) ? 8'hFF : glyphs[nib];
      if (!act_low) g = ~g;
      v[8*d +: 8] = g;
    end
    return v;
  endfunction

  task automatic model_segs();
    exp_seg0 = ref_seg(m_held, m_code, m_ascii, cnt_wrap16(m_raw), 4, 1'b1);
    exp_seg1 = 40'(ref_seg(m_held, m_code, m_ascii, cnt_wrap4(m_raw), 1, 1'b0));
    exp_seg2 = 40'(ref_seg(m_held, m_code, m_ascii, cnt_sat4(m_raw), 1, 1'b1));
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit same;
    if (ref_ctrl(b)) begin
      pend_ext = 0; pend_brk = 0;
    end else if (b == 8'hE0) begin
      if (pend_brk) begin pend_ext = 0; pend_brk = 0; end
      else pend_ext = 1;
    end else if (b == 8'hF0) begin
      if (pend_brk) begin pend_ext = 0; pend_brk = 0; end
      else pend_brk = 1;
    end else begin
      same = m_held && (m_ext == pend_ext) && (m_code == b);
      if (pend_brk) begin
        if (same) m_held = 0;
      end else if (!same) begin
        m_held  = 1;
        m_code  = b;
        m_ext   = pend_ext;
        m_ascii = ref_ascii(b, pend_ext);
        m_raw++;
      end
      pend_ext = 0; pend_brk = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i or posedge reset_i);
      if (reset_i) begin
        m_ready = 0; m_held = 0; m_ext = 0; pend_ext = 0; pend_brk = 0;
        m_code = 8'h00; m_ascii = 8'hFF; m_raw = 0;
        model_segs();
      end else begin
        model_segs();  // display lags the key state by one cycle
        if (code_valid_i && m_ready) model_byte(code_data_i);
        m_ready = 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_en) begin
        check("ready0", 64'(rdy0), 64'(m_ready));
        check("held0", 64'(held0), 64'(m_held));
        check("ext0", 64'(ext0), 64'(m_ext));
        check("code0", 64'(kc0), 64'(m_code));
        check("ascii0", 64'(ka0), 64'(m_ascii));
        check("cnt0", 64'(cnt0), 64'(cnt_wrap16(m_raw)));
        check("seg0", seg0, exp_seg0);
        check("held1", 64'(held1), 64'(m_held));
        check("cnt1", 64'(cnt1), 64'(cnt_wrap4(m_raw)));
        check("seg1", 64'(seg1), 64'(exp_seg1));
        check("ready2", 64'(rdy2), 64'(m_ready));
        check("cnt2", 64'(cnt2), 64'(cnt_sat4(m_raw)));
        check("seg2", 64'(seg2), 64'(exp_seg2));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    code_data_i  = b;
    code_valid_i = 1'b1;
    @(negedge clk_i);
    code_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    #2 reset_i = 1'b1;
    idle(2);
    reset_i = 1'b0;
    idle(1);
  endtask

  initial begin
    logic [7:0] b;
    int         r, p;
    reset_i      = 1'b1;
    code_valid_i = 1'b0;
    code_data_i  = 8'h00;
    idle(3);
    chk_en = 1;
    check("rst_seg0", seg0, 64'hC0C0C0C0FFFFFFFF);
    check("rst_ascii", 64'(ka0), 64'hFF);
    reset_i = 1'b0;
    idle(1);

    // Press and release 'A'
    send(8'h1C); idle(1);
    check("A_ascii", 64'(ka0), 64'h41);
    check("A_cnt", 64'(cnt0), 64'd1);
    check("A_seg0", seg0, 64'hC0C0C0F999F9F9C6);
    check("A_seg1", 64'(seg1), 64'h0666060639);
    send(8'hF0); send(8'h1C); idle(1);
    check("A_rel_held", 64'(held0), 64'd0);
    check("A_rel_seg0", seg0, 64'hC0C0C0F9FFFFFFFF);

    // Typematic repeat
    idle(1); do_reset();
    repeat (5) send(8'h16);
    idle(1);
    check("rep_cnt", 64'(cnt0), 64'd1);
    check("rep_ascii", 64'(ka0), 64'h31);
    check("rep_held", 64'(held0), 64'd1);
    send(8'hF0); send(8'h16); idle(1);
    check("rep_rel", 64'(held0), 64'd0);

    // Extended key; plain break must not release it
    idle(1); do_reset();
    send(8'hE0); send(8'h75); idle(1);
    check("ext_flag", 64'(ext0), 64'd1);
    check("ext_ascii", 64'(ka0), 64'hFF);
    send(8'hF0); send(8'h75); idle(1);
    check("ext_plain_brk", 64'(held0), 64'd1);
    send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    check("ext_brk", 64'(held0), 64'd0);

    // Rollover and release of a non-held key
    idle(1); do_reset();
    send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C); idle(1);
    check("roll_cnt", 64'(cnt0), 64'd2);
    check("roll_code", 64'(kc0), 64'h32);
    check("roll_held", 64'(held0), 64'd1);

    // Counter boundary
    idle(1); do_reset();
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
    idle(1);
    check("cnt_16", 64'(cnt0), 64'd16);
    check("cnt_wrap", 64'(cnt1), 64'd0);
    check("cnt_sat", 64'(cnt2), 64'hF);

    // Robustness
    idle(1); do_reset();
    send(8'hF0); send(8'hE0); send(8'h16); idle(1);
    check("rob_f0e0_cnt", 64'(cnt0), 64'd1);
    check("rob_f0e0_code", 64'(kc0), 64'h16);
    send(8'hE0); send(8'hAA); send(8'h75); idle(1);
    check("rob_aa_ext", 64'(ext0), 64'd0);
    check("rob_aa_cnt", 64'(cnt0), 64'd2);
    send(8'hE0);
    do_reset();
    check("rob_rst_cnt", 64'(cnt0), 64'd0);
    send(8'h75); idle(1);
    check("rob_rst_ext", 64'(ext0), 64'd0);
    check("rob_rst_cnt1", 64'(cnt0), 64'd1);

    // Randomised stream with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        code_valid_i = 1'b0;
        #2 reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
      end else begin
        p = $urandom_range(0, 9);
        if (p < 2)       b = 8'hE0;
        else if (p < 4)  b = 8'hF0;
        else if (p == 4) b = ctl_bytes[$urandom_range(0, 6)];
        else if (p == 5) b = 8'($urandom);
        else             b = key_pool[$urandom_range(0, 7)];
        code_data_i  = b;
        code_valid_i = (r % 4 != 0);
        @(negedge clk_i);
      end
    end
    code_valid_i = 1'b0;
    idle(3);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised successor to the single-scan-code keyboard display path. It consumes a stream of PS/2 set-2 bytes from the PS/2 receiver over a valid/ready handshake and decodes the prefix protocol (make, E0 extended, F0 break). It tracks the currently held key, maps it to ASCII (digits, letters, space), and counts distinct key presses with typematic repeats suppressed. It drives a flat bank of seven-segment digit codes for the board display.

Parameters:
CNT_DIGITS, 4, number of hex digits of the press counter; counter width CW = 4*CNT_DIGITS; legal range 1..8.
SEG_ACTIVE_LOW, 1, 1 = segment lit by 0 (board default); 0 = lit by 1.
CNT_SATURATE, 0, 0 = counter wraps to 0; 1 = counter holds at all-ones.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
code_data  in  8  PS/2 byte from receiver.
code_valid  in  1  code_data valid this cycle.
code_ready  out  1  byte accepted when code_valid & code_ready.
key_held  out  1  a key is currently held.
key_ext  out  1  held key carried the E0 prefix.
key_code  out  8  held key scan code (last released code retained).
key_ascii  out  8  ASCII of key_code; 0xFF if unmapped or extended.
press_cnt  out  CW  distinct press count.
seg  out  8*(4+CNT_DIGITS)  digit i occupies seg[8i+7:8i].

Behaviour:
- Reset (async assert; release synchronous to clk): FSM = IDLE, key_held=0, key_ext=0, key_code=0x00, key_ascii=0xFF, press_cnt=0, code_ready=0. All seg digits blank except the counter digits, which show '0'.
- code_ready is registered: 0 during reset, 1 from the first clk edge after reset deasserts, then 1 continuously. The block never back-pressures after that.
- FSM states: IDLE, E0, F0, E0F0. Transitions occur on an accepted byte only.
  - IDLE: E0 -> E0; F0 -> F0; data byte -> MAKE(ext=0), stay IDLE.
  - E0: E0 -> E0; F0 -> E0F0; data byte -> MAKE(ext=1), go IDLE.
  - F0: data byte -> BREAK(ext=0), go IDLE; E0 or F0 -> discard, go IDLE.
  - E0F0: data byte -> BREAK(ext=1), go IDLE; E0 or F0 -> discard, go IDLE.
- Control bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE and 0xFF are ignored in every state and force IDLE. A "data byte" is any byte other than E0, F0 and these control bytes.
- MAKE(c, e):
  - If key_held and {key_ext, key_code} == {e, c}, it is a typematic repeat: no change.
  - Otherwise: key_held=1, key_code=c, key_ext=e, press_cnt increments.
  - At press_cnt = all-ones: wraps to 0, or holds if CNT_SATURATE=1.
- BREAK(c, e): if key_held and {key_ext, key_code} == {e, c}, key_held=0. Otherwise no change; a release of a non-held key is ignored.
- Rollover: a MAKE of a new key while another is held replaces the held key and counts once.
- Latency:
  - key_* and press_cnt update on the clk edge that accepts the completing byte (cycle N).
  - key_ascii is registered from the ascii lookup in the same cycle N.
  - seg is registered one cycle later, at N+1.
- ASCII map (set-2 codes, ext=0 only):
  - Digits: 45->'0', 16->'1', 1E->'2', 26->'3', 25->'4', 2E->'5', 36->'6', 3D->'7', 3E->'8', 46->'9'.
  - Letters (uppercase): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Space: 29 -> 0x20.
  - All other codes, and every extended code -> 0xFF.
- Seg layout:
  - Digit 0 = key_code[3:0], digit 1 = key_code[7:4].
  - Digit 2 = key_ascii[3:0], digit 3 = key_ascii[7:4].
  - Digits 4.. = press_cnt nibbles, LSB nibble first.
- Seg bit order: [0]=a ... [6]=g, [7]=dp. dp is always off.
  - Hex glyphs are standard, with lowercase b and d.
  - Active-low values: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, blank=FF.
  - SEG_ACTIVE_LOW=0 inverts every value.
- Blanking: digits 0-3 are blank whenever key_held=0. Counter digits are never blank.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum.
  - Prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Control-byte constants.
  - ASCII_NONE=8'hFF.
  - SEG_BLANK.
  - hex-to-glyph function.
- One sub-module: ps2_ascii_lut. It is combinational: in code, ext; out ascii. The tracker instantiates it once.

Test Plan:
1. Reset, then send 1C, F0 1C. After 1C: key_held=1, key_ascii=0x41, press_cnt=1, seg digits 0..4 = C6 F9 F9 99 F9, digits 5-7 = C0. After F0 1C: key_held=0, digits 0-3 = FF, press_cnt stays 1.
2. Typematic: send 16 ×5, then F0 16 -> press_cnt=1, key_ascii=0x31, key_held cleared only after the F0 16.
3. Extended: send E0 75, then E0 F0 75 -> key_ext=1, key_ascii=0xFF, press_cnt+1. A plain F0 75 issued while E0 75 is held leaves key_held=1.
4. Rollover and bad release: 1C, 32, F0 1C -> press_cnt=2, key_code=0x32, key_held=1.
5. Counter boundary, with CNT_DIGITS=1: 16 alternating presses of two keys -> press_cnt wraps to 0. Repeat with CNT_SATURATE=1 -> press_cnt holds at F.
6. Robustness:
   - F0 E0 16 -> the first two bytes are discarded and 16 counts as a make.
   - 0xAA mid-sequence (E0 AA 75) -> 75 counts as a non-extended make.
   - reset asserted between E0 and 75 -> all outputs return to reset values, and 75 after reset counts as a non-extended make.
